param_keypad_lock: RTL
======================

// Module: param_keypad_lock
// PURPOSE
//   Parametrised two-button (0/1) combination lock: CODE_LEN-bit code, runtime-reprogrammable code,
//   failed-attempt counting with optional timed lockout. Next generation of the fixed 4-bit keypad
//   FSM; drives lock/unlock/reset status LEDs at top level.
// PARAMETERS
//   CODE_LEN     4         code length in button presses (>=2)
//   DEFAULT_CODE 4'b1000   code loaded at reset; first press = MSB
//   MAX_FAIL     3         consecutive failed attempts that trigger lockout (>=1)
//   LOCKOUT_CYC  16        lockout duration in CLK cycles (used only with KP_LOCKOUT_EN)
// PORTS
//   CLK     in   1                     system clock, rising edge
//   RST     in   1                     synchronous, active-high reset
//   ZBUT    in   1                     "0" button, level sampled each cycle
//   OBUT    in   1                     "1" button, level sampled each cycle
//   ENBL    in   1                     keypad enable; presses ignored while low
//   SECI    in   1                     set-code request (honoured only when unlocked)
//   LOCK    out  1                     registered: locked (LOCKED/LOCKOUT states)
//   ULCK    out  1                     registered: unlocked (UNLOCKED/PROG states)
//   RSTO    out  1                     1-cycle pulse on wrong code
//   SECV    out  1                     1-cycle pulse when new code committed
//   ostate  out  2                     current state encoding (debug)
//   offin   out  $clog2(CODE_LEN+1)    presses collected in current entry (debug)
// BEHAVIOUR
//   - Valid press: ENBL & (ZBUT ^ OBUT); bit = OBUT. Both or neither high -> no press, nothing changes.
//   - One press per cycle; held buttons count every cycle (debounce/edge-detect is upstream).
//   - Reset: state LOCKED, code<=DEFAULT_CODE, entry<=0, offin<=0, fail<=0;
//     LOCK=1, ULCK=0, RSTO=0, SECV=0, ostate=2'd0. RST wins over all other inputs.
//   - States (kp_state_t): LOCKED=0, UNLOCKED=1, PROG=2, LOCKOUT=3.
//   - LOCKED: press shifts bit into entry (MSB first), offin++. On press making offin==CODE_LEN:
//       match  -> next cycle UNLOCKED, LOCK=0, ULCK=1, fail<=0, offin<=0.
//       miss   -> next cycle RSTO=1 one cycle, offin<=0, fail<=fail+1 (saturating);
//                 if fail+1==MAX_FAIL -> LOCKOUT (macro) else stay LOCKED.
//     Latency: outputs change exactly 1 cycle after the final press edge.
//   - UNLOCKED: SECI=1 with ENBL=1 -> PROG (offin<=0). Valid press with SECI=0 -> relock to LOCKED,
//     press is consumed (not counted as code digit).
//   - PROG: presses collected as in LOCKED; on CODE_LEN-th press code<=new value, SECV=1 one cycle,
//     return to UNLOCKED. SECI dropping mid-entry -> abort to UNLOCKED, code unchanged, offin<=0.
//   - LOCKOUT: all presses ignored; timer counts LOCKOUT_CYC cycles, then LOCKED, fail<=0, offin<=0.
//   - fail counter width $clog2(MAX_FAIL+1); cleared on any successful unlock.
//   - Entry register is CODE_LEN bits; no partial-entry timeout.
// CONFIGURATION
//   KP_LOCKOUT_EN defined: LOCKOUT state and timer present as above.
//   KP_LOCKOUT_EN undefined: no LOCKOUT state/timer; reaching MAX_FAIL just clears fail and stays
//     LOCKED (RSTO pulse still issued); ostate never reads 3.
// STRUCTURE
//   keypad_pkg: kp_state_t enum (2-bit), state encodings, press-decode function.
//   Sub-module kp_lockout_timer (load/busy/done down-counter, width $clog2(LOCKOUT_CYC+1)),
//     instantiated only under KP_LOCKOUT_EN.
// TESTING (defaults unless noted)
//   1 RST, then presses 1,0,0,0 -> ULCK=1/LOCK=0 one cycle after 4th press, RSTO stays 0.
//   2 Presses 1,0,0,1 -> RSTO=1 for exactly 1 cycle, LOCK=1, offin=0, ostate=0.
//   3 Three wrong codes -> ostate=3, presses ignored 16 cycles, then ostate=0; 1000 then unlocks.
//   4 Unlocked, SECI=1, presses 0,1,1,0 -> SECV pulse; relock; 1000 fails, 0110 unlocks.
//   5 SECI dropped after 2 PROG presses -> UNLOCKED, code still 1000; ZBUT&OBUT together and
//     ENBL=0 presses never change offin.
//   6 RST asserted mid-entry (offin=2) and mid-lockout -> reset values next cycle; CODE_LEN=6 run
//     of test 1 with DEFAULT_CODE 6'b101101.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the parametrised keypad lock: FSM state encoding and press decode.
package keypad_pkg;

  typedef enum logic [1:0] {
    StLocked   = 2'd0,
    StUnlocked = 2'd1,
    StProg     = 2'd2,
    StLockout  = 2'd3
  } kp_state_t;

  // A press needs exactly one of the two buttons while the keypad is enabled.
  function automatic logic kp_press_valid(input logic enbl, input logic zbut, input logic obut);
    return enbl & (zbut ^ obut);
  endfunction

endpackage

// File: rtl/kp_lockout_timer.sv
// Load/busy/done down-counter; busy for exactly Cycles cycles after load, done on the last one.
module kp_lockout_timer #(
  parameter int unsigned Cycles = 16,
  localparam int unsigned CntW = $clog2(Cycles + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic busy_o,
  output logic done_o
);

  logic [CntW-1:0] cnt_q;
  logic            busy_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= CntW'(Cycles - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/param_keypad_lock.sv
// Two-button combination lock with reprogrammable code and failed-attempt counting.
// Define KP_LOCKOUT_EN to add the timed LOCKOUT state after MAX_FAIL consecutive misses.
module param_keypad_lock
  import keypad_pkg::*;
#(
  parameter int unsigned         CODE_LEN     = 4,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 4'b1000,
  parameter int unsigned         MAX_FAIL     = 3,
  parameter int unsigned         LOCKOUT_CYC  = 16,
  localparam int unsigned        OffW         = $clog2(CODE_LEN + 1),
  localparam int unsigned        FailW        = $clog2(MAX_FAIL + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ZBUT,
  input  logic            OBUT,
  input  logic            ENBL,
  input  logic            SECI,
  output logic            LOCK,
  output logic            ULCK,
  output logic            RSTO,
  output logic            SECV,
  output logic [1:0]      ostate,
  output logic [OffW-1:0] offin
);

  if (CODE_LEN < 2) begin : g_bad_len
    $error("CODE_LEN must be at least 2");
  end
  if (MAX_FAIL < 1) begin : g_bad_fail
    $error("MAX_FAIL must be at least 1");
  end
  if (LOCKOUT_CYC < 1) begin : g_bad_cyc
    $error("LOCKOUT_CYC must be at least 1");
  end

  kp_state_t           state_q;
  logic [CODE_LEN-1:0] code_q;
  logic [CODE_LEN-1:0] entry_q;
  logic [OffW-1:0]     offin_q;
  logic [FailW-1:0]    fail_q;
  logic                lock_q;
  logic                ulck_q;
  logic                rsto_q;
  logic                secv_q;

  logic                press;
  logic [CODE_LEN-1:0] entry_shift;
  logic                last_press;
  logic                code_match;
  logic                fail_limit;
  logic [FailW-1:0]    fail_inc;

  assign press       = kp_press_valid(ENBL, ZBUT, OBUT);
  assign entry_shift = {entry_q[CODE_LEN-2:0], OBUT};
  assign last_press  = (offin_q == OffW'(CODE_LEN - 1));
  assign code_match  = (entry_shift == code_q);
  assign fail_limit  = (int'(fail_q) + 1) >= int'(MAX_FAIL);
  assign fail_inc    = (fail_q == FailW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

`ifdef KP_LOCKOUT_EN
  logic lo_load;
  logic lo_busy;
  logic lo_done;

  assign lo_load = (state_q == StLocked) & press & last_press & ~code_match & fail_limit;

  kp_lockout_timer #(
    .Cycles (LOCKOUT_CYC)
  ) u_lockout_timer (
    .clk_i   (CLK),
    .reset_i (RST),
    .load_i  (lo_load),
    .busy_o  (lo_busy),
    .done_o  (lo_done)
  );
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StLocked;
      code_q  <= DEFAULT_CODE;
      entry_q <= '0;
      offin_q <= '0;
      fail_q  <= '0;
      lock_q  <= 1'b1;
      ulck_q  <= 1'b0;
      rsto_q  <= 1'b0;
      secv_q  <= 1'b0;
    end else begin
      rsto_q <= 1'b0;
      secv_q <= 1'b0;
      case (state_q)
        StLocked: begin
          if (press) begin
            entry_q <= entry_shift;
            if (last_press) begin
              offin_q <= '0;
              if (code_match) begin
                state_q <= StUnlocked;
                lock_q  <= 1'b0;
                ulck_q  <= 1'b1;
                fail_q  <= '0;
              end else begin
                rsto_q <= 1'b1;
                if (fail_limit) begin
`ifdef KP_LOCKOUT_EN
                  state_q <= StLockout;
                  fail_q  <= fail_inc;
`else
                  fail_q  <= '0;
`endif
                end else begin
                  fail_q <= fail_inc;
                end
              end
            end else begin
              offin_q <= offin_q + 1'b1;
            end
          end
        end
        StUnlocked: begin
          if (SECI && ENBL) begin
            state_q <= StProg;
            offin_q <= '0;
          end else if (press) begin
            // Relocking press is consumed; it does not start a new entry.
            state_q <= StLocked;
            lock_q  <= 1'b1;
            ulck_q  <= 1'b0;
          end
        end
        StProg: begin
          if (!SECI) begin
            state_q <= StUnlocked;
            offin_q <= '0;
          end else if (press) begin
            entry_q <= entry_shift;
            if (last_press) begin
              code_q  <= entry_shift;
              secv_q  <= 1'b1;
              state_q <= StUnlocked;
              offin_q <= '0;
            end else begin
              offin_q <= offin_q + 1'b1;
            end
          end
        end
`ifdef KP_LOCKOUT_EN
        StLockout: begin
          if (lo_busy && lo_done) begin
            state_q <= StLocked;
            fail_q  <= '0;
            offin_q <= '0;
          end
        end
`endif
        default: begin
          state_q <= StLocked;
          offin_q <= '0;
          lock_q  <= 1'b1;
          ulck_q  <= 1'b0;
        end
      endcase
    end
  end

  assign LOCK   = lock_q;
  assign ULCK   = ulck_q;
  assign RSTO   = rsto_q;
  assign SECV   = secv_q;
  assign ostate = state_q;
  assign offin  = offin_q;

endmodule
